// File: rtl/issue_mem_pkg.sv
// Shared constants and helpers for the issue memory arbiter slice.
package issue_mem_pkg;
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 18;
    localparam int MEM_DEPTH  = 61440;

    // Round-robin pointer width; a single requester still needs one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/issue_mem_arbiter_if.sv
// Requester and memory-side bus of the issue memory arbiter.
interface issue_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 18
);
    logic [NUM_REQ-1:0]        rd_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] rd_req_addr;
    logic [NUM_REQ-1:0]        rd_req_ready;
    logic [NUM_REQ-1:0]        rd_resp_valid;
    logic [NUM_REQ*DATA_W-1:0] rd_resp_data;
    logic [NUM_REQ-1:0]        wr_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] wr_req_addr;
    logic [NUM_REQ*DATA_W-1:0] wr_req_data;
    logic [NUM_REQ-1:0]        wr_req_ready;
    logic [ADDR_W-1:0]         mem_read_addr_a, mem_read_addr_b;
    logic [DATA_W-1:0]         mem_read_data_a, mem_read_data_b;
    logic [ADDR_W-1:0]         mem_write_addr_a, mem_write_addr_b;
    logic [DATA_W-1:0]         mem_write_data_a, mem_write_data_b;
    logic                      mem_write_en_a, mem_write_en_b;
    logic                      range_err;

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        input  mem_read_data_a, mem_read_data_b,
        output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
        output mem_read_addr_a, mem_read_addr_b,
        output mem_write_addr_a, mem_write_addr_b, mem_write_data_a, mem_write_data_b,
        output mem_write_en_a, mem_write_en_b, range_err
    );

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        output mem_read_data_a, mem_read_data_b,
        input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
        input  mem_read_addr_a, mem_read_addr_b,
        input  mem_write_addr_a, mem_write_addr_b, mem_write_data_a, mem_write_data_b,
        input  mem_write_en_a, mem_write_en_b, range_err
    );
endinterface

// File: rtl/issue_mem_arbiter_rr_pick2.sv
// Picks the first and second valid requesters scanning upward from ptr, modulo N.
module rr_pick2
    import issue_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic          first_vld,
    output logic [PW-1:0] first_idx,
    output logic [N-1:0]  first_oh,
    output logic          second_vld,
    output logic [PW-1:0] second_idx,
    output logic [N-1:0]  second_oh
);
    always_comb begin
        int idx;
        first_vld  = 1'b0;
        first_idx  = '0;
        first_oh   = '0;
        second_vld = 1'b0;
        second_idx = '0;
        second_oh  = '0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (valid[idx[PW-1:0]]) begin
                if (!first_vld) begin
                    first_vld              = 1'b1;
                    first_idx              = idx[PW-1:0];
                    first_oh[idx[PW-1:0]]  = 1'b1;
                end else if (!second_vld) begin
                    second_vld             = 1'b1;
                    second_idx             = idx[PW-1:0];
                    second_oh[idx[PW-1:0]] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/issue_mem_arbiter.sv
// Round-robin arbiter sharing the issue memory's two read and two write ports.
// Define ISSUE_ARB_BYPASS_EN for write-first forwarding on same-cycle read/write.
module issue_mem_arbiter
    import issue_mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int DEPTH   = MEM_DEPTH
) (
    input logic                clk,
    input logic                rst_n,
    issue_mem_arbiter_if.slave bus
);
    localparam int              PW      = ptr_w(NUM_REQ);
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_V;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic               rd_a_vld, rd_b_vld, wr_a_vld, wr_b_vld;
    logic [PW-1:0]      rd_a_idx, rd_b_idx, wr_a_idx, wr_b_idx;
    logic [NUM_REQ-1:0] rd_a_oh, rd_b_oh, wr_a_oh, wr_b_oh;

    rr_pick2 #(.N(NUM_REQ), .PW(PW)) u_rd_pick (
        .valid(bus.rd_req_valid), .ptr(rd_ptr),
        .first_vld(rd_a_vld), .first_idx(rd_a_idx), .first_oh(rd_a_oh),
        .second_vld(rd_b_vld), .second_idx(rd_b_idx), .second_oh(rd_b_oh)
    );

    rr_pick2 #(.N(NUM_REQ), .PW(PW)) u_wr_pick (
        .valid(bus.wr_req_valid), .ptr(wr_ptr),
        .first_vld(wr_a_vld), .first_idx(wr_a_idx), .first_oh(wr_a_oh),
        .second_vld(wr_b_vld), .second_idx(wr_b_idx), .second_oh(wr_b_oh)
    );

    logic [ADDR_W-1:0] rd_a_addr, rd_b_addr, wr_a_addr, wr_b_addr;
    logic [DATA_W-1:0] wr_a_data, wr_b_data;
    logic              wr_b_go, wr_a_en, wr_b_en, err_now;

    assign rd_a_addr = bus.rd_req_addr[rd_a_idx*ADDR_W +: ADDR_W];
    assign rd_b_addr = bus.rd_req_addr[rd_b_idx*ADDR_W +: ADDR_W];
    assign wr_a_addr = bus.wr_req_addr[wr_a_idx*ADDR_W +: ADDR_W];
    assign wr_b_addr = bus.wr_req_addr[wr_b_idx*ADDR_W +: ADDR_W];
    assign wr_a_data = bus.wr_req_data[wr_a_idx*DATA_W +: DATA_W];
    assign wr_b_data = bus.wr_req_data[wr_b_idx*DATA_W +: DATA_W];

    // Two writes to one address would race in the memory; the second one waits.
    assign wr_b_go = wr_b_vld && (wr_b_addr != wr_a_addr);
    assign wr_a_en = rst_n && wr_a_vld && in_range(wr_a_addr);
    assign wr_b_en = rst_n && wr_b_go && in_range(wr_b_addr);
    assign err_now = (rd_a_vld && !in_range(rd_a_addr)) || (rd_b_vld && !in_range(rd_b_addr)) ||
                     (wr_a_vld && !in_range(wr_a_addr)) || (wr_b_go && !in_range(wr_b_addr));

    assign bus.rd_req_ready     = rst_n ? (rd_a_oh | rd_b_oh) : '0;
    assign bus.wr_req_ready     = rst_n ? (wr_a_oh | (wr_b_go ? wr_b_oh : '0)) : '0;
    assign bus.mem_read_addr_a  = rd_a_vld ? rd_a_addr : '0;
    assign bus.mem_read_addr_b  = rd_b_vld ? rd_b_addr : '0;
    assign bus.mem_write_addr_a = wr_a_vld ? wr_a_addr : '0;
    assign bus.mem_write_data_a = wr_a_vld ? wr_a_data : '0;
    assign bus.mem_write_addr_b = wr_b_go ? wr_b_addr : '0;
    assign bus.mem_write_data_b = wr_b_go ? wr_b_data : '0;
    assign bus.mem_write_en_a   = wr_a_en;
    assign bus.mem_write_en_b   = wr_b_en;

    logic          resp_vld_a, resp_vld_b, resp_oor_a, resp_oor_b, range_err;
    logic [PW-1:0] resp_tag_a, resp_tag_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            resp_vld_a <= 1'b0;
            resp_vld_b <= 1'b0;
            resp_oor_a <= 1'b0;
            resp_oor_b <= 1'b0;
            resp_tag_a <= '0;
            resp_tag_b <= '0;
            range_err  <= 1'b0;
        end else begin
            if (rd_b_vld)      rd_ptr <= ptr_inc(rd_b_idx);
            else if (rd_a_vld) rd_ptr <= ptr_inc(rd_a_idx);
            if (wr_b_go)       wr_ptr <= ptr_inc(wr_b_idx);
            else if (wr_a_vld) wr_ptr <= ptr_inc(wr_a_idx);
            resp_vld_a <= rd_a_vld;
            resp_vld_b <= rd_b_vld;
            resp_oor_a <= !in_range(rd_a_addr);
            resp_oor_b <= !in_range(rd_b_addr);
            resp_tag_a <= rd_a_idx;
            resp_tag_b <= rd_b_idx;
            if (err_now) range_err <= 1'b1;
        end
    end

    assign bus.range_err = range_err;

    logic [DATA_W-1:0] port_data_a, port_data_b;

`ifdef ISSUE_ARB_BYPASS_EN
    logic              byp_a, byp_b;
    logic [DATA_W-1:0] byp_data_a, byp_data_b;

    // Port-a write wins when both write ports hit the read address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_a      <= 1'b0;
            byp_b      <= 1'b0;
            byp_data_a <= '0;
            byp_data_b <= '0;
        end else begin
            byp_a <= rd_a_vld && ((wr_a_en && wr_a_addr == rd_a_addr) ||
                                  (wr_b_en && wr_b_addr == rd_a_addr));
            byp_b <= rd_b_vld && ((wr_a_en && wr_a_addr == rd_b_addr) ||
                                  (wr_b_en && wr_b_addr == rd_b_addr));
            byp_data_a <= (wr_a_en && wr_a_addr == rd_a_addr) ? wr_a_data : wr_b_data;
            byp_data_b <= (wr_a_en && wr_a_addr == rd_b_addr) ? wr_a_data : wr_b_data;
        end
    end

    assign port_data_a = resp_oor_a ? '0 : (byp_a ? byp_data_a : bus.mem_read_data_a);
    assign port_data_b = resp_oor_b ? '0 : (byp_b ? byp_data_b : bus.mem_read_data_b);
`else
    assign port_data_a = resp_oor_a ? '0 : bus.mem_read_data_a;
    assign port_data_b = resp_oor_b ? '0 : bus.mem_read_data_b;
`endif

    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ*DATA_W-1:0] resp_data;

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (resp_vld_a) begin
            resp_valid[resp_tag_a]                = 1'b1;
            resp_data[resp_tag_a*DATA_W +: DATA_W] = port_data_a;
        end
        if (resp_vld_b) begin
            resp_valid[resp_tag_b]                = 1'b1;
            resp_data[resp_tag_b*DATA_W +: DATA_W] = port_data_b;
        end
    end

    assign bus.rd_resp_valid = rst_n ? resp_valid : '0;
    assign bus.rd_resp_data  = resp_data;
endmodule
